// File: rtl/ex_muldiv_if.sv
// Interface bundling the EX-stage HI/LO multiply/divide unit signals.
// The pipeline drives the master side; the unit implements the slave side.
interface ex_muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        mthi;
    logic        mtlo;
    logic        mf_req;
    logic        flush;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic        div_by_zero;

    modport master (
        output start, op, operand_a, operand_b, mthi, mtlo, mf_req, flush,
        input  hi_out, lo_out, busy, stall_req, done, div_by_zero
    );

    modport slave (
        input  start, op, operand_a, operand_b, mthi, mtlo, mf_req, flush,
        output hi_out, lo_out, busy, stall_req, done, div_by_zero
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative 32-cycle multiply/divide unit owning the architectural HI/LO registers.
// Signed ops run on magnitudes; signs are reapplied in a single fixup cycle.
module ex_muldiv (
    input  logic       clock,
    input  logic       reset_n,
    ex_muldiv_if.slave bus
);

    localparam logic [1:0] OpMult = 2'b00;
    localparam logic [1:0] OpDiv  = 2'b10;

    typedef enum logic [1:0] {StIdle, StCalc, StFixup} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opb_q, opb_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    logic        signed_op, a_neg, b_neg;
    logic [31:0] abs_a, abs_b;
    logic [32:0] add_sum;
    logic [63:0] mul_step;
    logic [32:0] rem_sh, rem_sub;
    logic [63:0] div_step;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    logic        div_zero;

    assign signed_op = ~bus.op[0];
    assign a_neg     = signed_op & bus.operand_a[31];
    assign b_neg     = signed_op & bus.operand_b[31];
    assign abs_a     = a_neg ? (~bus.operand_a + 32'd1) : bus.operand_a;
    assign abs_b     = b_neg ? (~bus.operand_b + 32'd1) : bus.operand_b;

    // Multiply: acc holds {partial product, remaining multiplier bits}; shift right each step.
    assign add_sum  = {1'b0, acc_q[63:32]} + {1'b0, opb_q};
    assign mul_step = acc_q[0] ? {add_sum, acc_q[31:1]} : {1'b0, acc_q[63:32], acc_q[31:1]};

    // Divide: acc holds {remainder, dividend/quotient}; bit 32 of rem_sub is the borrow.
    assign rem_sh   = {acc_q[63:32], acc_q[31]};
    assign rem_sub  = rem_sh - {1'b0, opb_q};
    assign div_step = rem_sub[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                                  : {rem_sub[31:0], acc_q[30:0], 1'b1};

    assign prod_fix = ((op_q == OpMult) && (sign_a_q ^ sign_b_q)) ? (~acc_q + 64'd1) : acc_q;
    assign quo_fix  = ((op_q == OpDiv) && (sign_a_q ^ sign_b_q)) ? (~acc_q[31:0] + 32'd1)
                                                                  : acc_q[31:0];
    assign rem_fix  = ((op_q == OpDiv) && sign_a_q) ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    assign div_zero = (opb_q == 32'd0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;

        if (bus.flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        op_d     = bus.op;
                        sign_a_d = a_neg;
                        sign_b_d = b_neg;
                        cnt_d    = 5'd31;
                        state_d  = StCalc;
                        if (bus.op[1]) begin
                            acc_d = {32'd0, abs_a};
                            opb_d = abs_b;
                        end else begin
                            acc_d = {32'd0, abs_b};
                            opb_d = abs_a;
                        end
                    end else begin
                        if (bus.mthi) hi_d = bus.operand_a;
                        if (bus.mtlo) lo_d = bus.operand_a;
                    end
                end
                StCalc: begin
                    acc_d = op_q[1] ? div_step : mul_step;
                    if (cnt_q == 5'd0) begin
                        state_d = StFixup;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                StFixup: begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                    if (!op_q[1]) begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end else if (div_zero) begin
                        // Remainder equals the magnitude of the dividend; sign fixup restores operand_a.
                        hi_d  = rem_fix;
                        lo_d  = 32'hFFFF_FFFF;
                        dbz_d = 1'b1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= 5'd0;
            op_q     <= 2'b00;
            acc_q    <= 64'd0;
            opb_q    <= 32'd0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.hi_out      = hi_q;
    assign bus.lo_out      = lo_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.stall_req   = (bus.busy & (bus.start | bus.mf_req | bus.mthi | bus.mtlo))
                           | ((state_q == StIdle) & bus.start & bus.mf_req);

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: expected HI/LO/flag results are queued at issue time and
// compared by an independent monitor whenever done pulses.
module tb_ex_muldiv;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    ex_muldiv_if bus ();

    ex_muldiv dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n && bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_hi", {32'd0, bus.hi_out}, {32'd0, e.hi});
                    check("sb_lo", {32'd0, bus.lo_out}, {32'd0, e.lo});
                    check("sb_dbz", {63'd0, bus.div_by_zero}, {63'd0, e.dbz});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_done(output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = 0;
        do begin
            @(posedge clock);
            #1;
            edges++;
            if (bus.busy) busy_cnt++;
        end while (!bus.done && edges < 60);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                          output int busy_total);
        int edges, bc;
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.start     = 1'b1;
        sb.push_back('{hi: ehi, lo: elo, dbz: edbz});
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        check("busy_after_start", {63'd0, bus.busy}, 64'd1);
        wait_done(edges, bc);
        check("latency", 64'(edges), 64'd33);
        busy_total = bc + 1;
    endtask

    initial begin
        int bt, n, dcount;
        bus.start = 0; bus.op = 0; bus.operand_a = 0; bus.operand_b = 0;
        bus.mthi = 0; bus.mtlo = 0; bus.mf_req = 0; bus.flush = 0;

        // Asynchronous reset before the first clock edge
        #2 reset_n = 1'b0;
        #1;
        check("rst_hi", {32'd0, bus.hi_out}, 64'd0);
        check("rst_lo", {32'd0, bus.lo_out}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_dbz", {63'd0, bus.div_by_zero}, 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, bt);
        check("multu_busy_cycles", 64'(bt), 64'd33);
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, bt);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, bt);
        run_op(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, bt);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, bt);
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, bt);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, bt);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, bt);
        run_op(2'b00, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, bt);

        // Stall: mf_req and a second start held while busy
        bus.op = 2'b01; bus.operand_a = 32'd6; bus.operand_b = 32'd7; bus.start = 1'b1;
        sb.push_back('{hi: 32'd0, lo: 32'd42, dbz: 1'b0});
        @(posedge clock);
        #1;
        bus.mf_req = 1'b1; bus.operand_a = 32'd2; bus.operand_b = 32'd3;
        n = 0;
        while (!bus.done && n < 60) begin
            check("stall_busy", {63'd0, bus.stall_req}, 64'd1);
            check("stall_hold", {bus.hi_out, bus.lo_out}, 64'hFFFF_FFFF_0000_0000);
            @(posedge clock);
            #1;
            n++;
        end
        check("stall_latency", 64'(n), 64'd33);
        bus.mf_req = 1'b0;
        #1;
        check("stall_released", {63'd0, bus.stall_req}, 64'd0);
        sb.push_back('{hi: 32'd0, lo: 32'd6, dbz: 1'b0});
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        check("second_start_accepted", {63'd0, bus.busy}, 64'd1);
        wait_done(n, bt);
        check("second_latency", 64'(n), 64'd33);

        // mthi/mtlo
        bus.operand_a = 32'hA5A5_A5A5; bus.mthi = 1'b1;
        @(posedge clock);
        #1;
        bus.mthi = 1'b0;
        check("mthi", {32'd0, bus.hi_out}, 64'h0000_0000_A5A5_A5A5);
        bus.operand_a = 32'h1234_5678; bus.mthi = 1'b1; bus.mtlo = 1'b1;
        @(posedge clock);
        #1;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        check("mthi_mtlo", {bus.hi_out, bus.lo_out}, 64'h1234_5678_1234_5678);

        // Flush at CALC cycle 10
        bus.op = 2'b01; bus.operand_a = 32'd9; bus.operand_b = 32'd9; bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        bus.flush = 1'b1;
        @(posedge clock);
        #1;
        bus.flush = 1'b0;
        check("flush_busy", {63'd0, bus.busy}, 64'd0);
        check("flush_hilo", {bus.hi_out, bus.lo_out}, 64'h1234_5678_1234_5678);
        dcount = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.done) dcount++;
        end
        check("flush_no_done", 64'(dcount), 64'd0);

        // Flush coinciding with FIXUP discards the result
        bus.op = 2'b01; bus.operand_a = 32'd9; bus.operand_b = 32'd9; bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (32) @(posedge clock);
        #1;
        bus.flush = 1'b1;
        @(posedge clock);
        #1;
        bus.flush = 1'b0;
        check("fixup_flush_done", {63'd0, bus.done}, 64'd0);
        check("fixup_flush_hilo", {bus.hi_out, bus.lo_out}, 64'h1234_5678_1234_5678);

        // Reset at CALC cycle 20, then MULTU 3*4 on the first edge after release
        bus.op = 2'b01; bus.operand_a = 32'hFFFF_FFFF; bus.operand_b = 32'd2; bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_hi", {32'd0, bus.hi_out}, 64'd0);
        check("midrst_lo", {32'd0, bus.lo_out}, 64'd0);
        check("midrst_busy", {63'd0, bus.busy}, 64'd0);
        check("midrst_done", {63'd0, bus.done}, 64'd0);
        check("midrst_dbz", {63'd0, bus.div_by_zero}, 64'd0);
        bus.op = 2'b01; bus.operand_a = 32'd3; bus.operand_b = 32'd4; bus.start = 1'b1;
        sb.push_back('{hi: 32'd0, lo: 32'd12, dbz: 1'b0});
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        check("post_rst_start", {63'd0, bus.busy}, 64'd1);
        wait_done(n, bt);
        check("post_rst_latency", 64'(n), 64'd33);

        repeat (3) @(posedge clock);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
